// File: rtl/sha256_job_scheduler.sv
// Job FIFO and launch/completion sequencer in front of a single simplified_sha256 engine.
// Define SHA256_SCHED_WATCHDOG_EN to build the per-job timeout watchdog.
module sha256_job_scheduler #(
  parameter int unsigned JOB_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [15:0]                  job_msg_addr,
  input  logic [15:0]                  job_out_addr,
  input  logic [3:0]                   job_tag,
  output logic                         eng_start,
  output logic [15:0]                  eng_message_addr,
  output logic [15:0]                  eng_output_addr,
  input  logic                         eng_done,
  output logic                         cpl_valid,
  input  logic                         cpl_ready,
  output logic [3:0]                   cpl_tag,
  output logic                         cpl_error,
  output logic                         busy,
  output logic [$clog2(JOB_DEPTH):0]   pending
);

  localparam int unsigned PtrW = $clog2(JOB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitLow,
    StWaitHigh,
    StReport
  } state_e;

  typedef struct packed {
    logic [15:0] msg;
    logic [15:0] out;
    logic [3:0]  tag;
  } job_t;

  job_t            mem_q [JOB_DEPTH];
  job_t            mem_d [JOB_DEPTH];
  job_t            head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full;
  logic            push;
  logic            pop;

  state_e          state_q, state_d;
  logic [15:0]     msg_q, msg_d;
  logic [15:0]     out_q, out_d;
  logic [3:0]      tag_q, tag_d;
  logic [3:0]      cpl_tag_q, cpl_tag_d;
  logic            eng_start_q, eng_start_d;
  logic            cpl_valid_q, cpl_valid_d;
  logic            busy_q, busy_d;
  logic            load_cpl;
  logic            load_err;
  logic            wd_expired;

  // No pass-through: a full FIFO refuses a push even when it pops this cycle.
  assign full = (count_q == CntW'(JOB_DEPTH));
  assign push = job_valid && !full;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{msg: job_msg_addr, out: job_out_addr, tag: job_tag};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    out_d     = out_q;
    tag_d     = tag_q;
    cpl_tag_d = cpl_tag_q;
    pop       = 1'b0;
    load_cpl  = 1'b0;
    load_err  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0 && eng_done) begin
          pop     = 1'b1;
          msg_d   = head.msg;
          out_d   = head.out;
          tag_d   = head.tag;
          state_d = StLaunch;
        end
      end
      StLaunch: state_d = StWaitLow;
      StWaitLow: begin
        if (!eng_done) begin
          state_d = StWaitHigh;
        end else if (wd_expired) begin
          state_d  = StReport;
          load_cpl = 1'b1;
          load_err = 1'b1;
        end
      end
      StWaitHigh: begin
        // A done rising on the timeout cycle still counts as a clean finish.
        if (eng_done) begin
          state_d  = StReport;
          load_cpl = 1'b1;
        end else if (wd_expired) begin
          state_d  = StReport;
          load_cpl = 1'b1;
          load_err = 1'b1;
        end
      end
      StReport: begin
        if (cpl_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (load_cpl) begin
      cpl_tag_d = tag_q;
    end
    eng_start_d = (state_d == StLaunch);
    cpl_valid_d = (state_d == StReport);
    busy_d      = (state_q != StIdle) || (count_q != '0);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      msg_q       <= '0;
      out_q       <= '0;
      tag_q       <= '0;
      cpl_tag_q   <= '0;
      eng_start_q <= 1'b0;
      cpl_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      msg_q       <= msg_d;
      out_q       <= out_d;
      tag_q       <= tag_d;
      cpl_tag_q   <= cpl_tag_d;
      eng_start_q <= eng_start_d;
      cpl_valid_q <= cpl_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SHA256_SCHED_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WdW-1:0] wd_q, wd_d;
  logic           cpl_error_q, cpl_error_d;

  // Saturating, and compared with >= so a late WAIT_HIGH entry still times out.
  assign wd_expired = (wd_q >= WdW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d = wd_q;
    if (state_q == StLaunch) begin
      wd_d = '0;
    end else if ((state_q == StWaitLow || state_q == StWaitHigh) && wd_q != '1) begin
      wd_d = wd_q + WdW'(1);
    end
    cpl_error_d = load_cpl ? load_err : cpl_error_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_q        <= '0;
      cpl_error_q <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      cpl_error_q <= cpl_error_d;
    end
  end

  assign cpl_error = cpl_error_q;
`else
  logic unused_wd;

  assign wd_expired = 1'b0;
  assign cpl_error  = 1'b0;
  assign unused_wd  = load_err ^ (TIMEOUT_CYCLES != 0);
`endif

  assign job_ready        = !full;
  assign eng_start        = eng_start_q;
  assign eng_message_addr = msg_q;
  assign eng_output_addr  = out_q;
  assign cpl_valid        = cpl_valid_q;
  assign cpl_tag          = cpl_tag_q;
  assign busy             = busy_q;
  assign pending          = count_q;

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Directed bench for sha256_job_scheduler with a behavioural engine model.
module tb_sha256_job_scheduler;

  localparam int unsigned Depth = 4;
  localparam int unsigned PendW = $clog2(Depth) + 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             job_valid;
  logic             job_ready;
  logic [15:0]      job_msg_addr;
  logic [15:0]      job_out_addr;
  logic [3:0]       job_tag;
  logic             eng_start;
  logic [15:0]      eng_message_addr;
  logic [15:0]      eng_output_addr;
  logic             eng_done = 1'b1;
  logic             cpl_valid;
  logic             cpl_ready;
  logic [3:0]       cpl_tag;
  logic             cpl_error;
  logic             busy;
  logic [PendW-1:0] pending;

  sha256_job_scheduler #(
    .JOB_DEPTH      (Depth),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_msg_addr     (job_msg_addr),
    .job_out_addr     (job_out_addr),
    .job_tag          (job_tag),
    .eng_start        (eng_start),
    .eng_message_addr (eng_message_addr),
    .eng_output_addr  (eng_output_addr),
    .eng_done         (eng_done),
    .cpl_valid        (cpl_valid),
    .cpl_ready        (cpl_ready),
    .cpl_tag          (cpl_tag),
    .cpl_error        (cpl_error),
    .busy             (busy),
    .pending          (pending)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cnt = 0;
  int   start_edge = -1;
  int   busy_len = 10;
  bit   eng_hang = 1'b0;
  int   eng_rem = 0;
  logic [3:0] log_tag[$];
  logic       log_err[$];

  // Engine model: done drops at the edge that samples start, rises busy_len edges later.
  always @(posedge clk) begin
    if (eng_start === 1'b1 && !eng_hang) begin
      eng_done <= 1'b0;
      eng_rem  <= busy_len - 1;
    end else if (!eng_done) begin
      if (eng_rem == 0) eng_done <= 1'b1;
      else eng_rem <= eng_rem - 1;
    end
  end

  // Edge counter, launch log and completion log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_start === 1'b1) begin
      start_cnt  <= start_cnt + 1;
      start_edge <= cyc + 1;
    end
    if (cpl_valid === 1'b1 && cpl_ready === 1'b1 && reset_n === 1'b1) begin
      log_tag.push_back(cpl_tag);
      log_err.push_back(cpl_error);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_job(input logic [15:0] m, input logic [15:0] o, input logic [3:0] t,
                          output int acc);
    bit ok = 1'b0;
    acc          = -1;
    job_msg_addr = m;
    job_out_addr = o;
    job_tag      = t;
    job_valid    = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      ok = (job_ready === 1'b1);
      @(negedge clk);
    end
    job_valid = 1'b0;
    if (ok) acc = cyc;
    else check("push_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_cpl(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      if (cpl_valid === 1'b1) at = cyc;
      else @(negedge clk);
    end
    if (at < 0) check("cpl_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && log_tag.size() < n; i++) @(negedge clk);
    check("log_count", log_tag.size(), n);
  endtask

  task automatic ack_cpl();
    cpl_ready = 1'b1;
    @(negedge clk);
    cpl_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc4;
    int at;
    int s0;
    int e;
    bit stable;

    reset_n      = 1'b0;
    job_valid    = 1'b0;
    job_msg_addr = '0;
    job_out_addr = '0;
    job_tag      = '0;
    cpl_ready    = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_job_ready", job_ready, 1);
    check("rst_eng_start", eng_start, 0);
    check("rst_cpl_valid", cpl_valid, 0);
    check("rst_cpl_tag", cpl_tag, 0);
    check("rst_cpl_error", cpl_error, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_msg_addr", eng_message_addr, 0);
    check("rst_out_addr", eng_output_addr, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single job with a 200-cycle engine.
    busy_len = 200;
    s0 = start_cnt;
    push_job(16'h0000, 16'h0100, 4'd3, acc);
    check("t1_pending", pending, 1);
    @(negedge clk);
    check("t1_start_hi", eng_start, 1);
    check("t1_msg", eng_message_addr, 16'h0000);
    check("t1_out", eng_output_addr, 16'h0100);
    @(negedge clk);
    check("t1_start_pulse", eng_start, 0);
    check("t1_start_edge", start_edge, acc + 2);
    check("t1_busy", busy, 1);
    stable = 1'b1;
    at = -1;
    for (int i = 0; i < 400 && at < 0; i++) begin
      if (eng_message_addr !== 16'h0000 || eng_output_addr !== 16'h0100) stable = 1'b0;
      if (cpl_valid === 1'b1) at = cyc;
      else @(negedge clk);
    end
    check("t1_addr_stable", stable, 1);
    check("t1_cpl_latency", at, acc + 2 + 201);
    check("t1_cpl_tag", cpl_tag, 3);
    check("t1_cpl_error", cpl_error, 0);
    check("t1_one_start", start_cnt, s0 + 1);
    ack_cpl();
    check("t1_cpl_drop", cpl_valid, 0);
    check("t1_out_hold", eng_output_addr, 16'h0100);

    // Fill the FIFO while a dummy job keeps the engine busy.
    busy_len = 30;
    cpl_ready = 1'b1;
    log_tag.delete();
    log_err.delete();
    push_job(16'h00A0, 16'h02A0, 4'hA, acc);
    repeat (3) @(negedge clk);
    for (int t = 0; t < 4; t++) push_job(16'h0010 * t, 16'h0200 + t, 4'(t), acc);
    check("fill_pending", pending, 4);
    check("fill_not_ready", job_ready, 0);
    push_job(16'h0040, 16'h0204, 4'd4, acc4);
    check("fill_tag4_after_pop", acc4, start_edge);
    wait_log(6, 1000);
    if (log_tag.size() == 6) begin
      check("fill_order_dummy", log_tag[0], 4'hA);
      for (int t = 0; t < 5; t++) begin
        check($sformatf("fill_order_%0d", t), log_tag[t+1], t);
        check($sformatf("fill_err_%0d", t), log_err[t+1], 0);
      end
    end

    // Completion backpressure.
    busy_len = 10;
    cpl_ready = 1'b0;
    log_tag.delete();
    log_err.delete();
    push_job(16'h0500, 16'h0600, 4'd5, acc);
    push_job(16'h0501, 16'h0601, 4'd6, acc);
    wait_cpl(100, at);
    s0 = start_cnt;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cpl_valid !== 1'b1 || cpl_tag !== 4'd5 || cpl_error !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    check("bp_record_stable", stable, 1);
    check("bp_no_start", start_cnt, s0);
    check("bp_pending", pending, 1);
    cpl_ready = 1'b1;
    @(negedge clk);
    e = cyc;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_launch", start_edge, e + 2);
    check("bp_next_addr", eng_message_addr, 16'h0501);
    wait_log(2, 200);
    if (log_tag.size() == 2) begin
      check("bp_order_0", log_tag[0], 5);
      check("bp_order_1", log_tag[1], 6);
    end

    // Simultaneous push and pop at occupancy 2.
    cpl_ready = 1'b0;
    log_tag.delete();
    log_err.delete();
    for (int t = 7; t < 10; t++) push_job(16'h0700 + t, 16'h0800 + t, 4'(t), acc);
    wait_cpl(100, at);
    check("pp_pending_pre", pending, 2);
    cpl_ready = 1'b1;
    @(negedge clk);
    check("pp_pending_idle", pending, 2);
    job_msg_addr = 16'h070A;
    job_out_addr = 16'h080A;
    job_tag      = 4'd10;
    job_valid    = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    check("pp_pending_same", pending, 2);
    check("pp_popped", eng_start, 1);
    check("pp_head_addr", eng_message_addr, 16'h0708);
    wait_log(4, 300);
    if (log_tag.size() == 4) begin
      for (int t = 0; t < 4; t++) check($sformatf("pp_order_%0d", t), log_tag[t], t + 7);
    end

`ifdef SHA256_SCHED_WATCHDOG_EN
    // Engine that never reacts to start.
    cpl_ready = 1'b0;
    eng_hang  = 1'b1;
    log_tag.delete();
    log_err.delete();
    push_job(16'h0C00, 16'h0D00, 4'hC, acc);
    push_job(16'h0C01, 16'h0D01, 4'hD, e);
    wait_cpl(300, at);
    check("wd_latency", at, acc + 2 + 64);
    check("wd_error", cpl_error, 1);
    check("wd_tag", cpl_tag, 4'hC);
    eng_hang = 1'b0;
    cpl_ready = 1'b1;
    wait_log(2, 300);
    if (log_tag.size() == 2) begin
      check("wd_next_tag", log_tag[1], 4'hD);
      check("wd_next_error", log_err[1], 0);
    end
`endif

    // Reset in WAIT_HIGH with two jobs queued.
    busy_len = 100;
    cpl_ready = 1'b1;
    log_tag.delete();
    log_err.delete();
    push_job(16'h0901, 16'h0A01, 4'd1, acc);
    push_job(16'h0902, 16'h0A02, 4'd2, acc);
    push_job(16'h0903, 16'h0A03, 4'd3, acc);
    repeat (10) @(negedge clk);
    check("mr_pending_pre", pending, 2);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mr_pending", pending, 0);
    check("mr_cpl_valid", cpl_valid, 0);
    check("mr_eng_start", eng_start, 0);
    check("mr_job_ready", job_ready, 1);
    check("mr_busy", busy, 0);
    check("mr_msg_addr", eng_message_addr, 0);
    s0 = start_cnt;
    repeat (150) @(negedge clk);
    check("mr_no_cpl", log_tag.size(), 0);
    check("mr_no_start", start_cnt, s0);
    check("mr_engine_idle", eng_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_job_scheduler.md
# sha256_job_scheduler

Front-end scheduler for the single `simplified_sha256` engine.
- Queues hash jobs (message address, output address, tag) in a small FIFO.
- Launches them one at a time with a one-cycle `start` pulse and holds the engine's address inputs stable for the whole job.
- Tracks the engine's `done` level through its low-then-high sequence and returns one completion record per job.
- An optional watchdog flags jobs whose engine never finishes.

## Interface
Parameters:
- `JOB_DEPTH`, 4: job FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in cycles, counted from the `LAUNCH` cycle.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `job_valid`  in  1  job offered.
- `job_ready`  out  1  FIFO not full.
- `job_msg_addr`  in  16  message word address.
- `job_out_addr`  in  16  hash output word address.
- `job_tag`  in  4  opaque job identifier.
- `eng_start`  out  1  start pulse to the engine.
- `eng_message_addr`  out  16  to engine `message_addr`.
- `eng_output_addr`  out  16  to engine `output_addr`.
- `eng_done`  in  1  engine `done`; a level, high while the engine is idle.
- `cpl_valid`  out  1  completion record available.
- `cpl_ready`  in  1  completion consumed.
- `cpl_tag`  out  4  tag of the completed job.
- `cpl_error`  out  1  job timed out.
- `busy`  out  1  state ≠ `IDLE` or FIFO non-empty.
- `pending`  out  $clog2(JOB_DEPTH)+1  FIFO occupancy.

## Operation
- **Job FIFO**
  - Push when `job_valid && job_ready`.
  - `job_ready = !full`, with no pass-through: a full FIFO refuses a push even if it pops in the same cycle.
  - A pop and a push in the same cycle leave `pending` unchanged.
  - Pointers wrap modulo `JOB_DEPTH`.
- **States:** `IDLE`, `LAUNCH`, `WAIT_LOW`, `WAIT_HIGH`, `REPORT`.
- **`IDLE`:** if the FIFO is non-empty and `eng_done == 1`:
  - pop the head entry;
  - latch its addresses and tag into the job registers;
  - go to `LAUNCH`.
- **`LAUNCH`:** `eng_start = 1` for this cycle only; go to `WAIT_LOW`.
- **`WAIT_LOW`:** wait for `eng_done == 0`, which proves the engine accepted the start; then go to `WAIT_HIGH`.
- **`WAIT_HIGH`:** wait for `eng_done == 1`; then load the completion record with `cpl_error = 0` and go to `REPORT`.
- **`REPORT`:**
  - `cpl_valid = 1`; `cpl_tag` and `cpl_error` are held stable.
  - On `cpl_ready` go to `IDLE`.
  - `cpl_valid` may not drop until `cpl_ready` is seen.
- **Address stability:** `eng_message_addr` and `eng_output_addr` change only on an `IDLE` pop. They hold their values through `LAUNCH` to `REPORT` and afterwards.
- **Watchdog** (see Configuration):
  - A counter clears in `LAUNCH` and increments in `WAIT_LOW` and `WAIT_HIGH`.
  - When it reaches `TIMEOUT_CYCLES - 1`, the FSM goes to `REPORT` with `cpl_error = 1`, whichever wait state it is in.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1 and it saturates rather than wrapping.
- **`done` rising on the timeout cycle:** normal completion wins and `cpl_error = 0`.
- **Reset** (synchronous, takes effect at the next edge even mid-job):
  - FSM returns to `IDLE`; FIFO is emptied; watchdog is cleared.
  - Every output returns to its reset value.
  - The engine is not reset by this block.

## Timing
- **Reset values:** `job_ready = 1`; all of `eng_start`, `cpl_valid`, `cpl_tag`, `cpl_error`, `busy`, `pending`, `eng_message_addr`, `eng_output_addr` = 0.
- All outputs are registered or decoded from state only; none depends combinationally on an input.
- **Launch latency:** a job pushed at edge N into an empty FIFO, with the FSM idle and `eng_done` high, gives `eng_start` high during cycle N+2.
- **Completion latency:** `cpl_valid` rises in the cycle after the edge at which `WAIT_HIGH` samples `eng_done == 1`.
- **Back-to-back:** minimum gap between successive `eng_start` pulses is engine busy time + 4 cycles, when `cpl_ready` is held high.
- **`busy`** follows state and occupancy with one cycle of register delay.

## Configuration
- Macro `SHA256_SCHED_WATCHDOG_EN`.
- **Defined:** the watchdog exists as described. A timed-out job produces `cpl_error = 1` and scheduling continues.
- **Not defined:**
  - No counter is synthesized.
  - `WAIT_LOW` and `WAIT_HIGH` wait indefinitely.
  - `cpl_error` is tied to 0.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- **Single job:** push msg=0x0000, out=0x0100, tag=3 into an idle scheduler with an engine model whose `done` stays low for 200 cycles.
  - `eng_start` is a single-cycle pulse at N+2.
  - Addresses stay 0x0000/0x0100 throughout.
  - Completion has `cpl_tag = 3`, `cpl_error = 0`.
- **Fill FIFO:** push 5 jobs (tags 0–4) with `JOB_DEPTH = 4` while the engine is busy.
  - `job_ready` drops after 4 accepted pushes.
  - Tag 4 is accepted only after the first pop.
  - Completions arrive in order 0..4.
- **Completion backpressure:** hold `cpl_ready = 0` for 50 cycles after `cpl_valid` rises.
  - Record stays stable.
  - No new `eng_start` is issued.
  - Next launch occurs 2 cycles after `cpl_ready` is accepted.
- **Watchdog** (macro defined, `TIMEOUT_CYCLES = 64`): engine never lowers `done`.
  - `cpl_valid` with `cpl_error = 1` at LAUNCH + 65 cycles.
  - The next queued job launches normally.
- **Mid-job reset:** assert `reset_n = 0` for 1 cycle in `WAIT_HIGH` with 2 jobs queued.
  - `pending = 0`, `cpl_valid = 0`, `eng_start = 0`, `job_ready = 1` the cycle after.
  - No completion is produced for the aborted job.
- **Simultaneous push/pop at occupancy 2:** `pending` stays 2 and FIFO order is preserved.
